lp805x_sfrmaster: RTL

LP805X_SFRMASTER -- requirements
Module: lp805x_sfrmaster

---
 rtl/lp805x_sfrmaster.sv | 100 ++++++++++
 1 files changed

// File: rtl/lp805x_sfrmaster.sv
// lp805x_sfrmaster: CPU-side master that packs SFR byte/bit requests onto the SFR command/response bus
module lp805x_sfrmaster #(
  parameter int                     TIMEOUT_LEN = 8,
  parameter logic [TIMEOUT_LEN-1:0] TIMEOUT_VAL = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_wr,
  input  logic        req_rd,
  input  logic        req_bit,
  input  logic [7:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        wbit,
  output logic        busy,
  output logic        rd_valid,
  output logic [7:0]  rdata,
  output logic        rbit,
  output logic        rd_timeout,
  output logic [28:0] sfr_bus,
  output logic        sfr_put,
  input  logic        sfr_wrdy,
  output logic        sfr_get,
  input  logic        sfr_rrdy,
  input  logic [7:0]  data_in,
  input  logic        bit_in
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, GET} state_t;
  state_t st_q, st_d;
  logic [28:0] bus_q, bus_d;
  logic [TIMEOUT_LEN-1:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic rbit_q, rbit_d, rv_q, rv_d, rto_q, rto_d;
  logic rd_only;
  assign rd_only    = ~req_wr & req_rd;
  assign busy       = st_q != IDLE;
  assign sfr_put    = (st_q == SEND) & sfr_wrdy;
  assign sfr_get    = (st_q == GET) | ((st_q == IDLE) & sfr_rrdy);
  assign sfr_bus    = bus_q;
  assign rdata      = rdata_q;
  assign rbit       = rbit_q;
  assign rd_valid   = rv_q;
  assign rd_timeout = rto_q;
  // Next-state: latch a request, push it once the FIFO has room, then await, time out or collect the response
  always_comb begin
    st_d    = st_q;
    bus_d   = bus_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rbit_d  = rbit_q;
    rv_d    = 1'b0;
    rto_d   = 1'b0;
    case (st_q)
      IDLE: if (req_wr | req_rd) begin
        st_d  = SEND;
        bus_d = {req_wr, rd_only, req_wr & req_bit, rd_only & req_bit, req_wr & req_bit & wbit,
                 req_wr ? addr : 8'h00, rd_only ? addr : 8'h00, (req_wr & ~req_bit) ? wdata : 8'h00};
      end
      SEND: if (sfr_wrdy) begin
        cnt_d = '0;
        st_d  = bus_q[28] ? IDLE : (sfr_rrdy ? GET : WAIT_RSP);
      end
      WAIT_RSP: if (sfr_rrdy) st_d = GET;
      else begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_LEN'(1);
        if (cnt_d == TIMEOUT_VAL) begin
          st_d    = IDLE;
          rdata_d = 8'hFF;
          rbit_d  = 1'b1;
          rv_d    = 1'b1;
          rto_d   = 1'b1;
        end
      end
      default: begin
        st_d    = IDLE;
        rdata_d = data_in;
        rbit_d  = bit_in;
        rv_d    = 1'b1;
      end
    endcase
  end
  // State and result registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q    <= IDLE;
      bus_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= 8'h00;
      rbit_q  <= 1'b0;
      rv_q    <= 1'b0;
      rto_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rbit_q  <= rbit_d;
      rv_q    <= rv_d;
      rto_q   <= rto_d;
    end
endmodule
